// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx: captures bytes strobed out of the core, buffers them and sends them as 8N1 UART.
`timescale 1ns/1ps

module stdout_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] stdout,
    input  logic       stdout_en,
    output logic       tx,
    output logic       stall,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nx;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_nx;
    logic [7:0]        shift;
    logic [7:0]        shift_nx;
    logic              tx_nx;
    logic              pop;

    logic              stdout_en_q;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nx;
    logic              push_req;
    logic              full;
    logic              push;
    logic              fifo_empty;
    logic              bit_end;

    // A held strobe is one byte: only the rising edge of stdout_en pushes.
    assign push_req   = stdout_en && !stdout_en_q;
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign push       = push_req && !full;
    assign fifo_empty = (count == '0);
    assign bit_end    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign count_nx   = count + CNT_W'(push) - CNT_W'(pop);
    assign busy       = (state != S_IDLE) || !fifo_empty;

    // Byte storage; contents are don't-care after reset since count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= stdout;
        end
    end

    // FIFO bookkeeping, strobe edge detect, stall and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stdout_en_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            stall       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            stdout_en_q <= stdout_en;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nx;
            // One spare entry absorbs the byte already in flight when stall rises.
            stall <= (count_nx >= CNT_W'(FIFO_DEPTH - 1));
            if (push_req && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmitter state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_idx  <= bit_nx;
            shift    <= shift_nx;
            tx       <= tx_nx;
        end
    end

    // Frame sequencing: start, 8 data bits LSB first, stop; chains frames with no gap.
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        shift_nx = shift;
        tx_nx    = tx;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nx = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    tx_nx    = 1'b0;
                    baud_nx  = '0;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    tx_nx    = shift[0];
                    state_nx = S_DATA;
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = S_STOP;
                    end else begin
                        shift_nx = {1'b0, shift[7:1]};
                        tx_nx    = shift[1];
                        bit_nx   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_nx = '0;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_nx = mem[rd_ptr];
                        tx_nx    = 1'b0;
                        state_nx = S_START;
                    end else begin
                        tx_nx    = 1'b1;
                        state_nx = S_IDLE;
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
